// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement adder/subtractor with the carry rippling
// through one CHUNK-bit slice per pipeline stage. It has a valid/ready stream
// handshake on both sides. All stages advance together, and they all stall
// together when the consumer applies backpressure.
module pipelined_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / CHUNK;

   // A width that does not split into whole slices has no meaningful pipeline.
   generate
      if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   // Global advance: every stage moves together or none do.
   logic adv;

   // Per-stage registers. Stage k has resolved slices 0..k of the sum.
   // The operands travel alongside, so later stages see their own slices
   // and the sign bits needed for the overflow flag.
   logic             v_q  [STAGES];
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic             c_q  [STAGES];
   logic             ovf_q;
   logic             zero_q;

   // Inputs presented to each stage: stage 0 takes the ports and later stages
   // take the previous stage's registers.
   logic             src_v [STAGES];
   logic [WIDTH-1:0] src_a [STAGES];
   logic [WIDTH-1:0] src_b [STAGES];
   logic [WIDTH-1:0] src_s [STAGES];
   logic             src_c [STAGES];

   // Values each stage will capture on the next advancing edge.
   logic [CHUNK:0]   slice_sum [STAGES];
   logic [WIDTH-1:0] nxt_s     [STAGES];
   logic             nxt_c     [STAGES];
   logic             ovf_d;
   logic             zero_d;

   assign adv       = !v_q[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign s         = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   // Route stage inputs. Subtraction folds into an add of ~b with the carry-in inverted.
   always_comb begin
      src_v[0] = in_valid;
      src_a[0] = a;
      src_b[0] = b ^ {WIDTH{sub}};
      src_s[0] = '0;
      src_c[0] = cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = v_q[k-1];
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_s[k] = s_q[k-1];
         src_c[k] = c_q[k-1];
      end
   end

   // Resolve one CHUNK-bit slice per stage using the carry from the stage before it.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional or partial write, otherwise synthesis infers a latch.
      for (int k = 0; k < STAGES; k++) begin
         nxt_s[k]     = src_s[k];
         slice_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + (CHUNK+1)'(src_c[k]);
         nxt_s[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
         nxt_c[k]     = slice_sum[k][CHUNK];
      end
   end

   // Status flags are formed as the final slice lands, so they register alongside s.
   always_comb begin
      ovf_d  = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1])
            && (nxt_s[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
      zero_d = (nxt_s[STAGES-1] == '0);
   end

   // Valid bits, partial sums, carries and flags shift forward on advance.
   // Asynchronous reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // samples the pre-edge value of its predecessor.
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= src_v[k];
            s_q[k] <= nxt_s[k];
            c_q[k] <= nxt_c[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   // Operand copies travel with their transaction. They are not reset.
   always_ff @(posedge clk) begin
      // NOTE: these are pure datapath registers that only matter when the
      // stage valid bit is set, so they carry no reset.
      if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed testbench for pipelined_addsub (WIDTH=16, CHUNK=4, four stages).
// Covers single-transaction latency, back-to-back throughput, a backpressure
// stall, and a mid-stream reset.
module tb_pipelined_addsub;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             cin       = 1'b0;
   logic             sub       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   int errors = 0;
   int checks = 0;

   pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Compare one observed value with its expected value.
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send one transaction into an empty pipeline.
   // Check that its result appears after exactly three more edges and lasts one cycle.
   task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
      a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      step();                                   // accepting edge n
      in_valid = 1'b0; a = ~va; b = ~vb; cin = ~vcin; sub = ~vsub;
      check({tag, " ov@n"}, 32'(out_valid), 32'd0);
      step();
      check({tag, " ov@n+1"}, 32'(out_valid), 32'd0);
      step();
      check({tag, " ov@n+2"}, 32'(out_valid), 32'd0);
      step();
      check({tag, " ov@n+3"}, 32'(out_valid), 32'd1);
      check({tag, " s"},      32'(s),    32'(es));
      check({tag, " cout"},   32'(cout), 32'(ec));
      check({tag, " ovf"},    32'(ovf),  32'(eo));
      check({tag, " zero"},   32'(zero), 32'(ez));
      step();
      check({tag, " ov@n+4"}, 32'(out_valid), 32'd0);
   endtask

   // Bound the run in case the design hangs in some unexpected way.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent;
      int got;

      // Reset state, sampled while rst_n is still low.
      #12;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst s",         32'(s),         32'd0);
      check("rst cout",      32'(cout),      32'd0);
      check("rst ovf",       32'(ovf),       32'd0);
      check("rst zero",      32'(zero),      32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("post-rst in_ready", 32'(in_ready), 32'd1);

      // Single transactions. Expected values are worked out by hand.
      run_one("add ffff+1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      run_one("sub 8000-1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run_one("sub 3-5",      16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_one("add 7fff+0+c", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      run_one("sub 10-5-1",   16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
      run_one("sub 1234-1234",16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // Back-to-back: a=i, b=0x1000*i, so s=0x1001*i with one result per cycle.
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            in_valid = 1'b1;
            a = 16'(c);
            b = 16'(c * 16'h1000);
            cin = 1'b0; sub = 1'b0;
            #1;
            check("b2b in_ready", 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c >= 3 && c < 11) begin
            check("b2b out_valid", 32'(out_valid), 32'd1);
            check("b2b s",         32'(s),         32'(16'(16'h1001 * (c - 3))));
         end else begin
            check("b2b idle", 32'(out_valid), 32'd0);
         end
      end

      // Backpressure: six transactions, with out_ready low on loop cycles 5..7.
      // Transaction i gives 0x0011*(i+1) + 0x0100.
      sent = 0;
      got  = 0;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 5 && c <= 7);
         in_valid  = (sent < 6);
         a   = 16'(16'h0011 * (sent + 1));
         b   = 16'h0100;
         cin = 1'b0; sub = 1'b0;
         #1;
         if (c == 5) check("stall engaged", 32'(out_valid), 32'd1);
         if (out_valid) begin
            if (got < 6) begin
               check("stall s",    32'(s),    32'(16'(16'h0011 * (got + 1) + 16'h0100)));
               check("stall zero", 32'(zero), 32'd0);
            end else begin
               check("stall extra result", 32'(out_valid), 32'd0);
            end
            if (!out_ready) check("stall in_ready", 32'(in_ready), 32'd0);
            else if (got < 6) got++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      check("stall all sent",     32'(sent), 32'd6);
      check("stall all consumed", 32'(got),  32'd6);

      // Mid-stream reset with four transactions in flight.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a = 16'(16'h0F00 + i);
         b = 16'h0000;
         step();
      end
      in_valid = 1'b0;
      check("pre-rst out_valid", 32'(out_valid), 32'd1);
      check("pre-rst s",         32'(s),         32'h0F00);
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst s",         32'(s),         32'd0);
      check("async rst cout",      32'(cout),      32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("no stale result", 32'(out_valid), 32'd0);
      end
      run_one("post-rst 1234+1", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the team's 4-bit ripple-carry full-adder chain. Width and pipeline depth are configurable, and the block adds carry-in, subtract mode, status flags and a valid/ready stream handshake. The carry ripples through one CHUNK-bit slice per pipeline stage, giving one result per clock at WIDTH/CHUNK cycles latency. It sits between an operand producer and a result consumer that may apply backpressure.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits resolved per pipeline stage. STAGES = WIDTH/CHUNK (derived, ≥1).
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  WIDTH  result.
- cout  out  1  raw carry out of bit WIDTH-1.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.

## Operation
- Effective operand: b_eff = b XOR {WIDTH{sub}}, c_eff = cin XOR sub. Result = a + b_eff + c_eff, modulo 2^WIDTH. sub=1, cin=0 gives a−b; sub=1, cin=1 gives a−b−1.
- cout is the carry out of the MSB. With sub=1, cout=1 means no borrow.
- ovf = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]).
- zero = (s == 0), registered alongside s.
- Stage k (0..STAGES-1) adds slice k (bits k·CHUNK .. k·CHUNK+CHUNK-1) using the carry registered by stage k-1; stage 0 uses c_eff. Unprocessed high slices of a and b_eff, plus completed low slices of s, travel with the transaction in per-stage registers. Each stage has a valid bit.
- The last stage registers drive s/cout/ovf/zero/out_valid directly. Outputs are registered, with no combinational path from inputs.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. On adv, every stage shifts forward one position (valid bits included). Without adv, all stages hold.
- A transaction is accepted on an edge where in_valid && in_ready. The result is consumed on an edge where out_valid && out_ready.
- Bubbles are not compressed: an empty stage still occupies a slot while stalled.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, s = 0, cout = 0, ovf = 0, zero = 0. in_ready = 1 as soon as reset is released (out_valid = 0).
- Latency: a transaction accepted on edge n, with adv true on each following edge, is presented on outputs immediately after edge n+STAGES-1. With STAGES = 1, the result is visible right after the accepting edge.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid=1 && out_ready=0 forces in_ready=0 in the same cycle. Outputs hold stable until consumed.
- Simultaneous accept and consume on one edge is legal; occupancy is unchanged.
- in_valid=0 while adv=1 inserts a bubble (stage valid = 0). Data registers in a bubble stage may hold anything; flags are only meaningful when out_valid=1.
- Reset asserted mid-stream discards all in-flight transactions immediately. The first transaction accepted after release obeys the normal latency.
- Operand inputs are sampled only on accepting edges; they may change freely otherwise.

## Test plan
(WIDTH=16, CHUNK=4, STAGES=4, out_ready=1 unless stated.)
- Add 0xFFFF + 0x0001, cin=0, sub=0, accepted at edge n -> after edge n+3: s=0x0000, cout=1, ovf=0, zero=1, out_valid=1 for exactly one cycle.
- Subtract 0x8000 − 0x0001 (sub=1, cin=0) -> s=0x7FFF, cout=1, ovf=1, zero=0. Then 0x0003 − 0x0005 -> s=0xFFFE, cout=0, ovf=0.
- Add 0x7FFF + 0x0000 with cin=1 -> s=0x8000, ovf=1, cout=0.
- 8 back-to-back transactions with a = i, b = 0x1000·i (i = 0..7) -> in_ready held 1; 8 consecutive out_valid cycles starting 3 edges after the first accept; s = 0x1001·i in order.
- Fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0 and s/flags stable throughout. After release, the remaining results appear in order with no loss or duplication.
- Assert rst_n low for one cycle with 4 transactions in flight -> out_valid=0 and s=0 immediately; no stale result ever appears. A fresh transaction (0x1234 + 0x0001) yields 0x1235 after normal latency.
